// File: rtl/uart_time_loader.sv
// uart_time_loader: 8N1 UART receiver that parses "HH:MM:SS" + CR/LF lines into a one-cycle time load strobe.
// Optional macro ERR_COUNT_EN adds err_count, a saturating error counter cleared on every load.
module uart_time_loader #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 115200
) (
  input logic CLOCK_50,
  input logic reset_n,
  input logic rx,
  output logic load,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [5:0] load_seconds,
  output logic busy,
`ifdef ERR_COUNT_EN
  output logic [7:0] err_count,
`endif
  output logic err
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  typedef enum logic [3:0] {P_H1, P_H2, P_C1, P_M1, P_M2, P_C2, P_S1, P_S2, P_END} p_state_t;
  logic rx_meta_q, rx_sync_q;
  rx_state_t rx_state_q, rx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic byte_stb, frame_err;
  p_state_t p_state_q, p_state_d;
  logic [23:0] dig_q, dig_d;
  logic load_q, load_d, err_q, err_d;
  logic [4:0] hours_q, hours_d;
  logic [5:0] mins_q, mins_d, secs_q, secs_d;
  logic [6:0] hours, mins, secs;
  logic is_digit, is_colon, is_term, want_digit, frame_ok;
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    shift_d = shift_q;
    byte_stb = 1'b0;
    frame_err = 1'b0;
    unique case (rx_state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        rx_state_d = rx_sync_q ? IDLE : START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d = '0;
        rx_state_d = rx_sync_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        shift_d = {rx_sync_q, shift_q[7:1]};
        bit_d = bit_q + 3'd1;
        rx_state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt_q == FULL) begin
        cnt_d = '0;
        byte_stb = rx_sync_q;
        frame_err = !rx_sync_q;
        rx_state_d = rx_sync_q ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_d = '0;
        rx_state_d = rx_sync_q ? IDLE : BREAK;
      end
      default: rx_state_d = IDLE;
    endcase
  end
  assign is_digit = (shift_q >= 8'h30) && (shift_q <= 8'h39);
  assign is_colon = shift_q == 8'h3A;
  assign is_term = (shift_q == 8'h0D) || (shift_q == 8'h0A);
  assign want_digit = !(p_state_q inside {P_C1, P_C2});
  // Digits shift in as a 6-nibble history; a complete line leaves HH MM SS in order.
  assign hours = 7'(dig_q[23:20]) * 7'd10 + 7'(dig_q[19:16]);
  assign mins = 7'(dig_q[15:12]) * 7'd10 + 7'(dig_q[11:8]);
  assign secs = 7'(dig_q[7:4]) * 7'd10 + 7'(dig_q[3:0]);
  assign frame_ok = is_term && (hours <= 7'd23) && (mins <= 7'd59) && (secs <= 7'd59);
  always_comb begin
    p_state_d = p_state_q;
    dig_d = dig_q;
    load_d = 1'b0;
    err_d = frame_err;
    hours_d = hours_q;
    mins_d = mins_q;
    secs_d = secs_q;
    if (frame_err) p_state_d = P_H1;
    else if (byte_stb) begin
      if (p_state_q == P_END) begin
        p_state_d = P_H1;
        load_d = frame_ok;
        err_d = !frame_ok;
        hours_d = frame_ok ? hours[4:0] : hours_q;
        mins_d = frame_ok ? mins[5:0] : mins_q;
        secs_d = frame_ok ? secs[5:0] : secs_q;
      end else if (p_state_q == P_H1 && is_term) p_state_d = P_H1;
      else if (want_digit ? is_digit : is_colon) begin
        p_state_d = p_state_t'(p_state_q + 4'd1);
        dig_d = want_digit ? {dig_q[19:0], shift_q[3:0]} : dig_q;
      end else begin
        p_state_d = P_H1;
        err_d = 1'b1;
      end
    end
  end
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      p_state_q <= P_H1;
      dig_q <= '0;
      load_q <= 1'b0;
      err_q <= 1'b0;
      hours_q <= '0;
      mins_q <= '0;
      secs_q <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_state_q <= rx_state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      p_state_q <= p_state_d;
      dig_q <= dig_d;
      load_q <= load_d;
      err_q <= err_d;
      hours_q <= hours_d;
      mins_q <= mins_d;
      secs_q <= secs_d;
    end
`ifdef ERR_COUNT_EN
  logic [7:0] ecnt_q, ecnt_d;
  assign ecnt_d = load_d ? 8'd0 : (err_d && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) ecnt_q <= '0;
    else ecnt_q <= ecnt_d;
  assign err_count = ecnt_q;
`endif
  assign load = load_q;
  assign err = err_q;
  assign load_hours = hours_q;
  assign load_minutes = mins_q;
  assign load_seconds = secs_q;
  assign busy = p_state_q != P_H1;
endmodule

// File: tb/tb_uart_time_loader.sv
// tb_uart_time_loader: scoreboard bench; expected loads are queued as lines are sent and popped on each load pulse.
module tb_uart_time_loader;
  localparam int CPB = 10;
  typedef struct {int h; int m; int s;} tm_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1;
  logic load, busy, err;
  logic [4:0] lh;
  logic [5:0] lm, ls;
`ifdef ERR_COUNT_EN
  logic [7:0] err_count;
`endif
  int checks = 0, errors = 0;
  int err_seen = 0, load_seen = 0;
  tm_t exp_q[$];
  tm_t e;
  always #5 clk = ~clk;
  uart_time_loader #(.CLK_HZ(1000000), .BAUD(100000)) dut (
    .CLOCK_50(clk),
    .reset_n(reset_n),
    .rx(rx),
    .load(load),
    .load_hours(lh),
    .load_minutes(lm),
    .load_seconds(ls),
    .busy(busy),
`ifdef ERR_COUNT_EN
    .err_count(err_count),
`endif
    .err(err)
  );
  always @(negedge clk) if (reset_n) begin
    if (load) begin
      load_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_load got %0d:%0d:%0d expected no load", lh, lm, ls);
      end else begin
        e = exp_q.pop_front();
        if ({lh, lm, ls} !== {5'(e.h), 6'(e.m), 6'(e.s)}) begin
          errors++;
          $display("FAIL load_value got %0d:%0d:%0d expected %0d:%0d:%0d", lh, lm, ls, e.h, e.m, e.s);
        end
      end
    end
    if (err) begin
      err_seen++;
      checks++;
      if (load) begin
        errors++;
        $display("FAIL load_err_exclusive got load=1 err=1 expected load=0 with err=1");
      end
    end
  end
  task automatic wait_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_bits(1);
    end
    rx = 1'b1;
    wait_bits(1);
  endtask
  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask
  task automatic push(input int h, input int m, input int s);
    tm_t t;
    t.h = h;
    t.m = m;
    t.s = s;
    exp_q.push_back(t);
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({load, lh, lm, ls, busy, err} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got %0h expected 0", {load, lh, lm, ls, busy, err});
    end
    reset_n = 1'b1;
    wait_bits(2);
  endtask
  task automatic test_single;
    int e0 = err_seen;
    push(12, 34, 56);
    send_byte("1");
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_line got %b expected 1", busy);
    end
    send_line("2:34:56");
    send_byte(8'h0A);
    wait_bits(3);
    checks++;
    if (exp_q.size() != 0 || err_seen != e0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_line got pending=%0d errs=%0d busy=%b expected pending=0 errs=0 busy=0", exp_q.size(), err_seen - e0, busy);
    end
  endtask
  task automatic test_range;
    int e0 = err_seen;
    int l0 = load_seen;
    send_line("24:00:00");
    send_byte(8'h0A);
    send_line("00:59:60");
    send_byte(8'h0A);
    wait_bits(3);
    checks++;
    if (err_seen - e0 != 2 || load_seen != l0) begin
      errors++;
      $display("FAIL range_reject got errs=%0d loads=%0d expected errs=2 loads=0", err_seen - e0, load_seen - l0);
    end
    checks++;
    if ({lh, lm, ls} !== {5'd12, 6'd34, 6'd56}) begin
      errors++;
      $display("FAIL range_retain got %0d:%0d:%0d expected 12:34:56", lh, lm, ls);
    end
    push(7, 5, 9);
    send_line("07:05:09");
    send_byte(8'h0A);
    wait_bits(3);
    checks++;
    if (exp_q.size() != 0 || err_seen - e0 != 2) begin
      errors++;
      $display("FAIL range_recover got pending=%0d errs=%0d expected pending=0 errs=2", exp_q.size(), err_seen - e0);
    end
  endtask
  task automatic test_back_to_back;
    int e0 = err_seen;
    int l0 = load_seen;
    push(23, 59, 59);
    push(0, 0, 0);
    send_line("23:59:59");
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_line("00:00:00");
    send_byte(8'h0D);
    send_byte(8'h0A);
    wait_bits(3);
    checks++;
    if (exp_q.size() != 0 || load_seen - l0 != 2 || err_seen != e0) begin
      errors++;
      $display("FAIL back_to_back got pending=%0d loads=%0d errs=%0d expected pending=0 loads=2 errs=0", exp_q.size(), load_seen - l0, err_seen - e0);
    end
  endtask
  task automatic test_syntax;
    int e0 = err_seen;
    int l0 = load_seen;
    send_line("12-34:56");
    send_byte(8'h0A);
    wait_bits(3);
    checks++;
    if (err_seen - e0 != 2 || load_seen != l0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL syntax_error got errs=%0d loads=%0d busy=%b expected errs=2 loads=0 busy=0", err_seen - e0, load_seen - l0, busy);
    end
`ifdef ERR_COUNT_EN
    checks++;
    if (err_count !== 8'd2) begin
      errors++;
      $display("FAIL err_count_syntax got %0d expected 2", err_count);
    end
`endif
  endtask
  task automatic test_break;
    int e0 = err_seen;
    send_byte("1");
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_break got %b expected 1", busy);
    end
    rx = 1'b0;
    wait_bits(30);
    rx = 1'b1;
    wait_bits(2);
    checks++;
    if (err_seen - e0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL line_break got errs=%0d busy=%b expected errs=1 busy=0", err_seen - e0, busy);
    end
    push(1, 2, 3);
    send_line("01:02:03");
    send_byte(8'h0A);
    wait_bits(3);
    checks++;
    if (exp_q.size() != 0 || err_seen - e0 != 1) begin
      errors++;
      $display("FAIL break_recover got pending=%0d errs=%0d expected pending=0 errs=1", exp_q.size(), err_seen - e0);
    end
`ifdef ERR_COUNT_EN
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("FAIL err_count_clear got %0d expected 0", err_count);
    end
`endif
  endtask
  task automatic test_glitch;
    int e0 = err_seen;
    int l0 = load_seen;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    wait_bits(3);
    checks++;
    if (err_seen != e0 || load_seen != l0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch got errs=%0d loads=%0d busy=%b expected 0 0 0", err_seen - e0, load_seen - l0, busy);
    end
  endtask
  task automatic test_mid_reset;
    int e0;
    logic [7:0] b;
    b = "2";
    send_line("11:2");
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      wait_bits(1);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({load, lh, lm, ls, busy, err} !== 19'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %0h expected 0", {load, lh, lm, ls, busy, err});
    end
    repeat (2) @(negedge clk);
    rx = 1'b1;
    reset_n = 1'b1;
    wait_bits(2);
    e0 = err_seen;
    push(11, 22, 33);
    send_line("11:22:33");
    send_byte(8'h0A);
    wait_bits(3);
    checks++;
    if (exp_q.size() != 0 || err_seen != e0) begin
      errors++;
      $display("FAIL mid_reset_recover got pending=%0d errs=%0d expected pending=0 errs=0", exp_q.size(), err_seen - e0);
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_range;
    test_back_to_back;
    test_syntax;
    test_break;
    test_glitch;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
